// File: rtl/multiplicador_seq_4bits.sv
// Sequential shift-and-add unsigned multiplier driving a WIDTH-bit ripple-carry adder once per bit.
// Define MULT_ZERO_BYPASS_EN to finish zero-operand jobs in one cycle instead of WIDTH.
module multiplicador_seq_4bits #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Produto
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_acc;
    logic               r_c;
    logic [CW-1:0]      r_count;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH:0]     w_carry;
    logic               w_cout;

    // r_c always shifts out as 0, so using it as carry-in keeps Cin=0 for every add.
    always_comb begin
        w_addend   = r_q[0] ? r_m : '0;
        w_carry    = '0;
        w_carry[0] = r_c;
        w_sum      = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_sum[i]       = r_acc[i] ^ w_addend[i] ^ w_carry[i];
            w_carry[i + 1] = (r_acc[i] & w_addend[i]) | (w_carry[i] & (r_acc[i] ^ w_addend[i]));
        end
        w_cout = w_carry[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_q     <= '0;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_count <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Produto <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_m     <= A;
                        r_q     <= B;
                        r_acc   <= '0;
                        r_c     <= 1'b0;
                        r_count <= '0;
                        busy    <= 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
                        if ((A == '0) || (B == '0)) begin
                            Produto <= '0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
`else
                        r_state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    // {C,acc,Q} <= {0, cout, sum, Q} >> 1
                    r_c     <= 1'b0;
                    r_acc   <= {w_cout, w_sum[WIDTH-1:1]};
                    r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        Produto <= {w_cout, w_sum, r_q[WIDTH-1:1]};
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_seq_4bits.sv
// Scoreboard bench for multiplicador_seq_4bits: driver pushes expected product and due cycle,
// monitor pops on every done pulse. Honors MULT_ZERO_BYPASS_EN for latency expectations.
module tb_multiplicador_seq_4bits;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] Produto;

    multiplicador_seq_4bits #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Produto (Produto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  prod;
        int unsigned due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Offset from accept edge to the cycle in which done is seen high.
    function automatic int unsigned done_off(input logic [3:0] a, input logic [3:0] b);
`ifdef MULT_ZERO_BYPASS_EN
        if (a == 4'd0 || b == 4'd0) return 0;
`endif
        return 4;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got Produto=%0d with empty scoreboard (cycle %0d)", Produto, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("produto", Produto, e.prod);
                check("done_cycle", cyc, e.due);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", busy, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("done_timeout_pending", sb.size(), 0);
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [7:0] prod);
        exp_t e;
        wait_idle();
        A     = a;
        B     = b;
        start = 1'b1;
        e.prod = prod;
        e.due  = cyc + 1 + done_off(a, b);
        sb.push_back(e);
        tick();
        start = 1'b0;
    endtask

    initial begin
        int          nbusy;
        int unsigned prev_issue;
        int unsigned prev_off;
        bit          first;
        exp_t        e;

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_produto", Produto, 0);
        rst_n = 1'b1;
        tick();

        // 15*15, busy for 5 cycles
        issue(4'd15, 4'd15, 8'hE1);
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 20) begin
            nbusy++;
            tick();
        end
        check("busy_cycles", nbusy, 5);
        wait_done();

        // 9*6 then 1*1; Produto must hold 54 while the second job runs
        issue(4'd9, 4'd6, 8'h36);
        wait_done();
        check("produto_after_9x6", Produto, 8'h36);
        issue(4'd1, 4'd1, 8'h01);
        tick();
        tick();
        check("produto_hold", Produto, 8'h36);
        check("done_low_mid_calc", done, 0);
        wait_done();

        // start pulse while busy is ignored; A/B changes have no effect
        issue(4'd3, 4'd5, 8'h0F);
        A     = 4'd7;
        B     = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        repeat (8) tick();
        check("no_extra_done", sb.size(), 0);

        // reset mid-CALC aborts the job
        wait_idle();
        A     = 4'd12;
        B     = 4'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_produto", Produto, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        issue(4'd12, 4'd10, 8'h78);
        wait_done();

        // zero operands
        issue(4'd0, 4'd13, 8'h00);
        wait_done();
        issue(4'd13, 4'd0, 8'h00);
        wait_done();
        issue(4'd2, 4'd8, 8'h10);
        wait_done();

        // exhaustive, start held high; check spacing between accepts
        first      = 1'b1;
        prev_issue = 0;
        prev_off   = 0;
        start      = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                wait_idle();
                A      = 4'(a);
                B      = 4'(b);
                e.prod = 8'(a * b);
                e.due  = cyc + 1 + done_off(4'(a), 4'(b));
                sb.push_back(e);
                if (!first) check("job_spacing", cyc - prev_issue, prev_off + 2);
                first      = 1'b0;
                prev_issue = cyc;
                prev_off   = done_off(4'(a), 4'(b));
                tick();
            end
        end
        start = 1'b0;
        wait_done();
        repeat (10) tick();
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
